// File: rtl/joystick_pkg.sv
// Shared definitions for the ADC joystick sampler.
//   ADC_W             : ADC sample width
//   CH_W              : ADC channel field width
//   CH_Y_DEF/CH_X_DEF : default joystick channel numbers
//   dir_t             : direction code (00 up, 01 down, 10 left, 11 right)
//   state_t           : sampler FSM states
`timescale 1ns/1ps
package joystick_pkg;

    localparam int ADC_W = 12;
    localparam int CH_W  = 5;

    localparam logic [CH_W-1:0] CH_Y_DEF = 5'd1;
    localparam logic [CH_W-1:0] CH_X_DEF = 5'd2;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_Y = 3'd1,
        S_WAIT_Y  = 3'd2,
        S_ISSUE_X = 3'd3,
        S_WAIT_X  = 3'd4
    } state_t;

endpackage

// File: rtl/adc_joystick_sampler_if.sv
// Command/response stream bundle between the sampler and the modular ADC.
//   cmd_valid/cmd_channel/cmd_ready : conversion request handshake
//   rsp_valid/rsp_channel/rsp_data  : conversion result (no back-pressure)
// modport master : sampler side (issues commands, consumes responses)
// modport slave  : ADC side
`timescale 1ns/1ps
interface adc_joystick_sampler_if;
    import joystick_pkg::*;

    logic             cmd_valid;
    logic [CH_W-1:0]  cmd_channel;
    logic             cmd_ready;
    logic             rsp_valid;
    logic [CH_W-1:0]  rsp_channel;
    logic [ADC_W-1:0] rsp_data;

    modport master (
        output cmd_valid,
        output cmd_channel,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_channel,
        input  rsp_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_channel,
        output cmd_ready,
        output rsp_valid,
        output rsp_channel,
        output rsp_data
    );

endinterface

// File: rtl/joystick_direction.sv
// Combinational deadzone/hysteresis and dominant-axis direction decode.
//   x_avg, y_avg     : averaged axis samples
//   dir_active       : current (registered) activity flag
//   dir_next         : dominant-axis direction for these averages
//   dir_active_next  : activity flag after applying deadzone with hysteresis
// The parent decides when these are registered and holds dir when inactive.
`timescale 1ns/1ps
module joystick_direction
    import joystick_pkg::*;
#(
    parameter logic [ADC_W-1:0] CENTER   = 12'd2048,
    parameter int               DEADZONE = 512,
    parameter int               HYST     = 64
) (
    input  logic [ADC_W-1:0] x_avg,
    input  logic [ADC_W-1:0] y_avg,
    input  logic             dir_active,
    output dir_t             dir_next,
    output logic             dir_active_next
);

    localparam logic [ADC_W:0] ON_TH  = (ADC_W+1)'(DEADZONE);
    localparam logic [ADC_W:0] OFF_TH = (ADC_W+1)'(DEADZONE - HYST);

    logic signed [ADC_W:0] dx;
    logic signed [ADC_W:0] dy;
    logic        [ADC_W:0] abs_dx;
    logic        [ADC_W:0] abs_dy;
    logic        [ADC_W:0] mag;
    logic                  x_dominant;

    // One extra bit keeps the offset from centre exact for any 12-bit input.
    assign dx = $signed({1'b0, x_avg}) - $signed({1'b0, CENTER});
    assign dy = $signed({1'b0, y_avg}) - $signed({1'b0, CENTER});

    assign abs_dx = dx[ADC_W] ? (ADC_W+1)'(-dx) : (ADC_W+1)'(dx);
    assign abs_dy = dy[ADC_W] ? (ADC_W+1)'(-dy) : (ADC_W+1)'(dy);

    // Ties resolve to the X axis.
    assign x_dominant = (abs_dx >= abs_dy);
    assign mag        = x_dominant ? abs_dx : abs_dy;

    always_comb begin
        dir_active_next = dir_active;
        dir_next        = UP;

        // Engage above DEADZONE, release only below DEADZONE - HYST.
        if (!dir_active) begin
            dir_active_next = (mag > ON_TH);
        end else begin
            dir_active_next = !(mag < OFF_TH);
        end

        if (x_dominant) begin
            dir_next = (dx > 13'sd0) ? RIGHT : LEFT;
        end else begin
            dir_next = (dy > 13'sd0) ? UP : DOWN;
        end
    end

endmodule

// File: rtl/adc_joystick_sampler.sv
// Paced joystick sampler for the MAX10 modular ADC.
// Alternately requests Y then X conversions, pairs the responses, box-car
// averages 2^AVG_LOG2 pairs and derives a debounced direction code.
//   Clk, Reset    : clock and asynchronous active-high reset
//   adc           : command/response streams (master side)
//   x_avg, y_avg  : averaged axis samples (CENTER after reset)
//   dir           : 00 up, 01 down, 10 left, 11 right
//   dir_active    : joystick outside the deadzone
//   sample_strobe : one-cycle pulse when averages/direction update
//   timeout_err   : sticky, set when a response never arrived
`timescale 1ns/1ps
module adc_joystick_sampler
    import joystick_pkg::*;
#(
    parameter int               AVG_LOG2 = 2,
    parameter logic [ADC_W-1:0] CENTER   = 12'd2048,
    parameter int               DEADZONE = 512,
    parameter int               HYST     = 64,
    parameter int               TIMEOUT  = 255,
    parameter logic [CH_W-1:0]  CH_Y     = CH_Y_DEF,
    parameter logic [CH_W-1:0]  CH_X     = CH_X_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    adc_joystick_sampler_if.master  adc,
    output logic [ADC_W-1:0]        x_avg,
    output logic [ADC_W-1:0]        y_avg,
    output logic [1:0]              dir,
    output logic                    dir_active,
    output logic                    sample_strobe,
    output logic                    timeout_err
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TO_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] PAIRS_C   = CNT_W'(1 << AVG_LOG2);
    localparam logic [TO_W-1:0]  TIMEOUT_C = TO_W'(TIMEOUT);

    state_t             state_q,       state_d;
    logic [TO_W-1:0]    wait_cnt_q,    wait_cnt_d;
    logic [ADC_W-1:0]   y_tmp_q,       y_tmp_d;
    logic [ACC_W-1:0]   acc_x_q,       acc_x_d;
    logic [ACC_W-1:0]   acc_y_q,       acc_y_d;
    logic [CNT_W-1:0]   pair_cnt_q,    pair_cnt_d;
    logic               cmd_valid_q,   cmd_valid_d;
    logic [CH_W-1:0]    cmd_channel_q, cmd_channel_d;
    logic [ADC_W-1:0]   x_avg_q,       x_avg_d;
    logic [ADC_W-1:0]   y_avg_q,       y_avg_d;
    dir_t               dir_q,         dir_d;
    logic               dir_active_q,  dir_active_d;
    logic               strobe_q,      strobe_d;
    logic               timeout_err_q, timeout_err_d;

    logic               dump_now;
    logic [ADC_W-1:0]   x_avg_new;
    logic [ADC_W-1:0]   y_avg_new;
    logic [ACC_W-1:0]   acc_x_base;
    logic [ACC_W-1:0]   acc_y_base;
    logic [CNT_W-1:0]   pair_base;
    dir_t               dir_nx;
    logic               dir_active_nx;
    logic               rsp_is_y;
    logic               rsp_is_x;

    // A full window is dumped in the cycle after the last pair lands.
    assign dump_now  = (pair_cnt_q == PAIRS_C);
    assign x_avg_new = ADC_W'(acc_x_q >> AVG_LOG2);
    assign y_avg_new = ADC_W'(acc_y_q >> AVG_LOG2);

    assign rsp_is_y = adc.rsp_valid && (adc.rsp_channel == CH_Y);
    assign rsp_is_x = adc.rsp_valid && (adc.rsp_channel == CH_X);

    // Direction is judged on the averages being published this cycle.
    joystick_direction #(
        .CENTER   (CENTER),
        .DEADZONE (DEADZONE),
        .HYST     (HYST)
    ) u_direction (
        .x_avg           (x_avg_new),
        .y_avg           (y_avg_new),
        .dir_active      (dir_active_q),
        .dir_next        (dir_nx),
        .dir_active_next (dir_active_nx)
    );

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        y_tmp_d       = y_tmp_q;
        x_avg_d       = x_avg_q;
        y_avg_d       = y_avg_q;
        dir_d         = dir_q;
        dir_active_d  = dir_active_q;
        strobe_d      = 1'b0;
        timeout_err_d = timeout_err_q;
        cmd_valid_d   = 1'b0;
        cmd_channel_d = cmd_channel_q;
        acc_x_base    = acc_x_q;
        acc_y_base    = acc_y_q;
        pair_base     = pair_cnt_q;

        if (dump_now) begin
            x_avg_d      = x_avg_new;
            y_avg_d      = y_avg_new;
            strobe_d     = 1'b1;
            dir_active_d = dir_active_nx;
            if (dir_active_nx) begin
                dir_d = dir_nx;
            end
            // A pair completing in this same cycle starts the next window.
            acc_x_base = '0;
            acc_y_base = '0;
            pair_base  = '0;
        end

        acc_x_d    = acc_x_base;
        acc_y_d    = acc_y_base;
        pair_cnt_d = pair_base;

        case (state_q)
            S_IDLE: begin
                state_d = S_ISSUE_Y;
            end
            S_ISSUE_Y: begin
                if (adc.cmd_ready) begin
                    state_d    = S_WAIT_Y;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT_Y: begin
                wait_cnt_d = wait_cnt_q + TO_W'(1);
                if (rsp_is_y) begin
                    y_tmp_d = adc.rsp_data;
                    state_d = S_ISSUE_X;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_ISSUE_Y;
                end
            end
            S_ISSUE_X: begin
                if (adc.cmd_ready) begin
                    state_d    = S_WAIT_X;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT_X: begin
                wait_cnt_d = wait_cnt_q + TO_W'(1);
                if (rsp_is_x) begin
                    acc_x_d    = acc_x_base + ACC_W'(adc.rsp_data);
                    acc_y_d    = acc_y_base + ACC_W'(y_tmp_q);
                    pair_cnt_d = pair_base + CNT_W'(1);
                    state_d    = S_ISSUE_Y;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    // Stale y_tmp is simply never accumulated.
                    timeout_err_d = 1'b1;
                    state_d       = S_ISSUE_Y;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Command outputs are registered copies of the next state.
        if (state_d == S_ISSUE_Y) begin
            cmd_valid_d   = 1'b1;
            cmd_channel_d = CH_Y;
        end else if (state_d == S_ISSUE_X) begin
            cmd_valid_d   = 1'b1;
            cmd_channel_d = CH_X;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            y_tmp_q       <= '0;
            acc_x_q       <= '0;
            acc_y_q       <= '0;
            pair_cnt_q    <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_channel_q <= '0;
            x_avg_q       <= CENTER;
            y_avg_q       <= CENTER;
            dir_q         <= UP;
            dir_active_q  <= 1'b0;
            strobe_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            y_tmp_q       <= y_tmp_d;
            acc_x_q       <= acc_x_d;
            acc_y_q       <= acc_y_d;
            pair_cnt_q    <= pair_cnt_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_channel_q <= cmd_channel_d;
            x_avg_q       <= x_avg_d;
            y_avg_q       <= y_avg_d;
            dir_q         <= dir_d;
            dir_active_q  <= dir_active_d;
            strobe_q      <= strobe_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign adc.cmd_valid   = cmd_valid_q;
    assign adc.cmd_channel = cmd_channel_q;
    assign x_avg           = x_avg_q;
    assign y_avg           = y_avg_q;
    assign dir             = dir_q;
    assign dir_active      = dir_active_q;
    assign sample_strobe   = strobe_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_adc_joystick_sampler.sv
// Directed bench for adc_joystick_sampler with a small ADC response model.
`timescale 1ns/1ps
module tb_adc_joystick_sampler;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic [11:0] x_avg;
    logic [11:0] y_avg;
    logic [1:0]  dir;
    logic        dir_active;
    logic        sample_strobe;
    logic        timeout_err;

    int n_err    = 0;
    int n_checks = 0;

    adc_joystick_sampler_if adc_if ();

    adc_joystick_sampler dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .adc           (adc_if),
        .x_avg         (x_avg),
        .y_avg         (y_avg),
        .dir           (dir),
        .dir_active    (dir_active),
        .sample_strobe (sample_strobe),
        .timeout_err   (timeout_err)
    );

    always #5 Clk = ~Clk;

    // ---------------- ADC model ----------------
    // Accepts a command seen valid&ready at a falling edge, answers three
    // falling edges later. Any 4 consecutive responses on a channel cover
    // its table exactly once, so a window average equals the table mean.
    int          x_tab [4];
    int          y_tab [4];
    int          x_idx      = 0;
    int          y_idx      = 0;
    int          pend       = 0;
    logic [4:0]  pend_ch    = 5'd0;
    bit          stray_en   = 1'b0;
    int          drop_arm   = 0;
    int          drops_done = 0;
    bit          y_poison   = 1'b0;

    always @(negedge Clk) begin
        adc_if.rsp_valid   = 1'b0;
        adc_if.rsp_channel = 5'd0;
        adc_if.rsp_data    = 12'd0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                if (pend_ch == 5'd1) begin
                    adc_if.rsp_valid   = 1'b1;
                    adc_if.rsp_channel = 5'd1;
                    if (drop_arm > drops_done) begin
                        adc_if.rsp_data = 12'd4000;
                        y_poison = 1'b1;
                    end else begin
                        adc_if.rsp_data = 12'(y_tab[y_idx]);
                        y_idx = (y_idx + 1) % 4;
                    end
                end else if (y_poison) begin
                    y_poison   = 1'b0;
                    drops_done = drops_done + 1;
                end else begin
                    adc_if.rsp_valid   = 1'b1;
                    adc_if.rsp_channel = 5'd2;
                    adc_if.rsp_data    = 12'(x_tab[x_idx]);
                    x_idx = (x_idx + 1) % 4;
                end
            end else if (stray_en && pend == 2) begin
                adc_if.rsp_valid   = 1'b1;
                adc_if.rsp_channel = 5'd5;
                adc_if.rsp_data    = 12'hFFF;
            end
        end
        if (pend == 0 && adc_if.cmd_valid === 1'b1 && adc_if.cmd_ready === 1'b1) begin
            pend    = 3;
            pend_ch = adc_if.cmd_channel;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_tabs(input int yv, input int xv);
        for (int i = 0; i < 4; i++) begin
            y_tab[i] = yv;
            x_tab[i] = xv;
        end
    endtask

    task automatic expect_window(input string tag, input int ex_x, input int ex_y,
                                 input int ex_dir, input int ex_act, input int ex_to);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge Clk);
            if (sample_strobe === 1'b1) seen = 1'b1;
        end
        check($sformatf("%s_strobe", tag), 32'(seen), 32'd1);
        check($sformatf("%s_x_avg", tag), 32'(x_avg), 32'(ex_x));
        check($sformatf("%s_y_avg", tag), 32'(y_avg), 32'(ex_y));
        check($sformatf("%s_dir", tag), 32'(dir), 32'(ex_dir));
        check($sformatf("%s_dir_active", tag), 32'(dir_active), 32'(ex_act));
        check($sformatf("%s_timeout_err", tag), 32'(timeout_err), 32'(ex_to));
        @(negedge Clk);
        check($sformatf("%s_pulse_len", tag), 32'(sample_strobe), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int chans [4];
        int nch;
        bit found;

        adc_if.cmd_ready = 1'b0;
        set_tabs(2048, 2048);

        // Reset state
        repeat (2) @(negedge Clk);
        check("rst_cmd_valid", 32'(adc_if.cmd_valid), 32'd0);
        check("rst_cmd_channel", 32'(adc_if.cmd_channel), 32'd0);
        check("rst_x_avg", 32'(x_avg), 32'd2048);
        check("rst_y_avg", 32'(y_avg), 32'd2048);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_dir_active", 32'(dir_active), 32'd0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        Reset = 1'b0;

        // Command held while ready is low
        repeat (4) @(negedge Clk);
        check("hold_cmd_valid", 32'(adc_if.cmd_valid), 32'd1);
        check("hold_cmd_channel", 32'(adc_if.cmd_channel), 32'd1);
        @(posedge Clk);
        #1 adc_if.cmd_ready = 1'b1;

        // Channel alternation
        nch = 0;
        for (int i = 0; i < 100 && nch < 4; i++) begin
            @(negedge Clk);
            if (adc_if.cmd_valid === 1'b1) begin
                chans[nch] = 32'(adc_if.cmd_channel);
                nch++;
            end
        end
        check("chan_seq_count", 32'(nch), 32'd4);
        check("chan_seq_0", 32'(chans[0]), 32'd1);
        check("chan_seq_1", 32'(chans[1]), 32'd2);
        check("chan_seq_2", 32'(chans[2]), 32'd1);
        check("chan_seq_3", 32'(chans[3]), 32'd2);

        expect_window("centre", 2048, 2048, 0, 0, 0);

        x_tab[0] = 3000; x_tab[1] = 3000; x_tab[2] = 3000; x_tab[3] = 3004;
        expect_window("right_avg", 3001, 2048, 3, 1, 0);

        set_tabs(2048, 2500);
        expect_window("hyst_hold", 2500, 2048, 3, 1, 0);

        set_tabs(2048, 2400);
        expect_window("hyst_release", 2400, 2048, 3, 0, 0);

        set_tabs(2048, 2560);
        expect_window("dz_edge", 2560, 2048, 3, 0, 0);

        set_tabs(1000, 2048);
        expect_window("down", 2048, 1000, 1, 1, 0);

        set_tabs(2648, 2648);
        expect_window("tie_x", 2648, 2648, 3, 1, 0);

        set_tabs(2648, 2048);
        expect_window("up", 2048, 2648, 0, 1, 0);

        set_tabs(2048, 1000);
        expect_window("left", 1000, 2048, 2, 1, 0);

        stray_en = 1'b1;
        set_tabs(2048, 2048);
        expect_window("stray", 2048, 2048, 2, 0, 0);

        stray_en = 1'b0;
        drop_arm = 1;
        expect_window("drop", 2048, 2048, 2, 0, 1);

        set_tabs(2048, 3000);
        expect_window("pre_reset", 3000, 2048, 3, 1, 1);

        // Reset while waiting for an X response
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge Clk);
            if (adc_if.cmd_valid === 1'b1 && adc_if.cmd_channel === 5'd2) found = 1'b1;
        end
        check("find_issue_x", 32'(found), 32'd1);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("arst_x_avg", 32'(x_avg), 32'd2048);
        check("arst_y_avg", 32'(y_avg), 32'd2048);
        check("arst_dir", 32'(dir), 32'd0);
        check("arst_dir_active", 32'(dir_active), 32'd0);
        check("arst_timeout_err", 32'(timeout_err), 32'd0);
        check("arst_cmd_valid", 32'(adc_if.cmd_valid), 32'd0);
        // In-flight X response carries a value that must not leak in.
        set_tabs(2048, 1000);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        #1 set_tabs(2048, 2048);
        expect_window("post_reset", 2048, 2048, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
